// File: rtl/hpdcache_sram_wbuf_1rw.sv
// Front-end for a 1RW byte-enable data SRAM with a one-entry coalescing
// write buffer, read forwarding and a 1-cycle valid/ready read response.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/ready/we        request handshake, 1=write 0=read
//   req_addr/wdata/wbe        request row address, data, byte enables
//   rsp_valid/ready/rdata     read response channel
//   flush                     drain the buffer and block new writes
//   wbuf_empty                write buffer holds nothing
//   sram_cs/we/addr/wdata/
//   sram_wbyteenable          SRAM macro command
//   sram_rdata                SRAM macro read data (held until next read)
module hpdcache_sram_wbuf_1rw #(
    parameter int unsigned ADDR_SIZE = 6,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned NDATA     = 1,
    parameter int unsigned MAX_HOLD  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [ADDR_SIZE-1:0]           req_addr,
    input  logic [NDATA*DATA_SIZE-1:0]     req_wdata,
    input  logic [NDATA*DATA_SIZE/8-1:0]   req_wbe,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [NDATA*DATA_SIZE-1:0]     rsp_rdata,
    input  logic                           flush,
    output logic                           wbuf_empty,
    output logic                           sram_cs,
    output logic                           sram_we,
    output logic [ADDR_SIZE-1:0]           sram_addr,
    output logic [NDATA*DATA_SIZE-1:0]     sram_wdata,
    output logic [NDATA*DATA_SIZE/8-1:0]   sram_wbyteenable,
    input  logic [NDATA*DATA_SIZE-1:0]     sram_rdata
);

    localparam int unsigned DW = NDATA * DATA_SIZE;
    localparam int unsigned BW = DW / 8;
    localparam logic [7:0]  HOLD_MAX = 8'(MAX_HOLD);

    logic                 wbuf_valid_q;
    logic [ADDR_SIZE-1:0] wbuf_addr_q;
    logic [DW-1:0]        wbuf_data_q;
    logic [BW-1:0]        wbuf_be_q;
    logic [7:0]           hold_cnt_q;
    logic                 rsp_pending_q;
    logic [BW-1:0]        fwd_be_q;
    logic [DW-1:0]        fwd_data_q;

    logic          force_drain;
    logic          rd_ok;
    logic          wr_ok;
    logic          rd_acc;
    logic          wr_acc;
    logic          wr_nop;
    logic          addr_hit;
    logic          wr_evict;
    logic          drain;
    logic [DW-1:0] merged_data;

    assign force_drain = wbuf_valid_q & ((hold_cnt_q == HOLD_MAX) | flush);
    assign rd_ok       = !force_drain & (!rsp_pending_q | rsp_ready);
    assign wr_ok       = !force_drain & !flush;
    assign req_ready   = !rst & (req_we ? wr_ok : rd_ok);
    assign rd_acc      = req_valid & !req_we & req_ready;
    assign wr_acc      = req_valid & req_we & req_ready;
    // An all-zero byte-enable write is accepted but touches nothing.
    assign wr_nop      = wr_acc & ~|req_wbe;
    assign addr_hit    = wbuf_valid_q & (wbuf_addr_q == req_addr);
    assign wr_evict    = wr_acc & !wr_nop & wbuf_valid_q & !addr_hit;
    // Idle cycles are used to retire the buffered write opportunistically.
    assign drain       = force_drain | wr_evict
                       | (!rd_acc & !wr_acc & wbuf_valid_q);

    assign sram_cs          = !rst & (drain | rd_acc);
    assign sram_we          = !rst & drain;
    assign sram_addr        = drain ? wbuf_addr_q : req_addr;
    assign sram_wdata       = wbuf_data_q;
    assign sram_wbyteenable = drain ? wbuf_be_q : '0;

    assign rsp_valid  = !rst & rsp_pending_q;
    assign wbuf_empty = rst | !wbuf_valid_q;

    always_comb begin
        merged_data = wbuf_data_q;
        rsp_rdata   = sram_rdata;
        for (int i = 0; i < int'(BW); i++) begin
            if (req_wbe[i]) merged_data[i*8 +: 8] = req_wdata[i*8 +: 8];
            if (fwd_be_q[i]) rsp_rdata[i*8 +: 8] = fwd_data_q[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_valid_q  <= 1'b0;
            hold_cnt_q    <= 8'd0;
            rsp_pending_q <= 1'b0;
            fwd_be_q      <= '0;
        end else begin
            if (rd_acc) begin
                rsp_pending_q <= 1'b1;
            end else if (rsp_pending_q && rsp_ready) begin
                rsp_pending_q <= 1'b0;
            end

            // Snapshot so later coalescing cannot change this response.
            if (rd_acc) begin
                fwd_be_q   <= addr_hit ? wbuf_be_q : '0;
                fwd_data_q <= wbuf_data_q;
                if (wbuf_valid_q && hold_cnt_q < HOLD_MAX) begin
                    hold_cnt_q <= hold_cnt_q + 8'd1;
                end
            end

            if (wr_acc && !wr_nop) begin
                if (addr_hit) begin
                    wbuf_data_q <= merged_data;
                    wbuf_be_q   <= wbuf_be_q | req_wbe;
                end else begin
                    wbuf_valid_q <= 1'b1;
                    wbuf_addr_q  <= req_addr;
                    wbuf_data_q  <= req_wdata;
                    wbuf_be_q    <= req_wbe;
                    hold_cnt_q   <= 8'd0;
                end
            end else if (drain) begin
                wbuf_valid_q <= 1'b0;
                hold_cnt_q   <= 8'd0;
            end
        end
    end

endmodule
